// File: rtl/cms_axis_downsizer.sv
// Wide-to-narrow AXI-Stream serialiser for monitoring trace packets.
// Emits each held item least-significant slice first, one beat per cycle.
module cms_axis_downsizer #(
    parameter int IN_WIDTH  = 1024,
    parameter int OUT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
    input  logic                 S_AXIS_tvalid,
    output logic                 S_AXIS_tready,
    input  logic                 S_AXIS_tlast,
    output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
    output logic                 M_AXIS_tvalid,
    input  logic                 M_AXIS_tready,
    output logic                 M_AXIS_tlast,
    output logic [31:0]          items_done
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IW    = $clog2(RATIO);
    localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [IN_WIDTH-1:0]  hold;
    logic                 hold_last;
    logic [IW-1:0]        idx;
    logic [31:0]          done_cnt;

    logic full;
    logic last_beat;
    logic beat;
    logic take;

    assign full      = (state == SEND);
    assign last_beat = (idx == LAST_IDX);
    assign beat      = full && M_AXIS_tready;
    assign take      = S_AXIS_tvalid && S_AXIS_tready;
    assign items_done = done_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: if (S_AXIS_tvalid) state_nx = SEND;
            SEND:  if (beat && last_beat && !S_AXIS_tvalid) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    // Upstream may refill in the same cycle the final slice leaves.
    always_comb begin
        S_AXIS_tready = !full || (M_AXIS_tready && last_beat);
        M_AXIS_tvalid = full;
        M_AXIS_tdata  = hold[OUT_WIDTH-1:0];
        M_AXIS_tlast  = full && hold_last && last_beat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            hold_last <= 1'b0;
            idx       <= '0;
            done_cnt  <= '0;
        end else begin
            if (take) begin
                hold      <= S_AXIS_tdata;
                hold_last <= S_AXIS_tlast;
                idx       <= '0;
            end else if (beat && !last_beat) begin
                hold <= {{OUT_WIDTH{1'b0}}, hold[IN_WIDTH-1:OUT_WIDTH]};
                idx  <= idx + IW'(1);
            end else if (beat) begin
                idx <= '0;
            end
            if (beat && last_beat) begin
                done_cnt <= done_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_cms_axis_downsizer.sv
// Randomised bench for cms_axis_downsizer against a queue-based beat model.
// Directed scenarios pin the model with hand-computed literals.
module tb_cms_axis_downsizer;

    localparam int IW = 1024;
    localparam int OW = 64;
    localparam int R  = IW / OW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] S_AXIS_tdata = '0;
    logic          S_AXIS_tvalid = 1'b0;
    logic          S_AXIS_tready;
    logic          S_AXIS_tlast = 1'b0;
    logic [OW-1:0] M_AXIS_tdata;
    logic          M_AXIS_tvalid;
    logic          M_AXIS_tready = 1'b1;
    logic          M_AXIS_tlast;
    logic [31:0]   items_done;

    cms_axis_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .S_AXIS_tdata(S_AXIS_tdata),
        .S_AXIS_tvalid(S_AXIS_tvalid),
        .S_AXIS_tready(S_AXIS_tready),
        .S_AXIS_tlast(S_AXIS_tlast),
        .M_AXIS_tdata(M_AXIS_tdata),
        .M_AXIS_tvalid(M_AXIS_tvalid),
        .M_AXIS_tready(M_AXIS_tready),
        .M_AXIS_tlast(M_AXIS_tlast),
        .items_done(items_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] d;
        logic          l;
        logic          fin;
    } exp_t;

    typedef struct {
        logic [OW-1:0] d;
        logic          l;
        int            c;
    } rec_t;

    exp_t        q[$];
    rec_t        got[$];
    int          hs[$];
    logic [31:0] model_done = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        rnd = 1'b0;
    logic        stall = 1'b0;
    logic [OW-1:0] stall_d = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream ready: always high, or a fair coin when rnd is set.
    always @(posedge clk) begin
        #1;
        M_AXIS_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: inputs and outputs are stable at the falling edge.
    always @(negedge clk) begin
        exp_t b;
        logic exp_sr;
        cyc++;
        if (!rst_n) begin
            chk("rst_m_valid", M_AXIS_tvalid, 0);
            chk("rst_m_data", M_AXIS_tdata, 0);
            chk("rst_m_last", M_AXIS_tlast, 0);
            chk("rst_s_ready", S_AXIS_tready, 1);
            chk("rst_items", items_done, 0);
            q.delete();
            model_done = '0;
            stall = 1'b0;
        end else begin
            chk("items_done", items_done, model_done);
            chk("m_valid", M_AXIS_tvalid, q.size() != 0);
            exp_sr = (q.size() == 0) || (M_AXIS_tready && q.size() == 1);
            chk("s_ready", S_AXIS_tready, exp_sr);
            if (q.size() != 0) begin
                chk("m_data", M_AXIS_tdata, q[0].d);
                chk("m_last", M_AXIS_tlast, q[0].l);
            end
            if (stall) chk("stall_data", M_AXIS_tdata, stall_d);
            stall = M_AXIS_tvalid && !M_AXIS_tready;
            stall_d = M_AXIS_tdata;
            if (M_AXIS_tvalid && M_AXIS_tready && q.size() != 0) begin
                b = q.pop_front();
                got.push_back('{b.d, b.l, cyc});
                if (b.fin) model_done = model_done + 32'd1;
            end
            if (S_AXIS_tvalid && S_AXIS_tready) begin
                hs.push_back(got.size());
                for (int k = 0; k < R; k++)
                    q.push_back('{S_AXIS_tdata[k*OW +: OW],
                                  S_AXIS_tlast && (k == R - 1), k == R - 1});
            end
        end
    end

    task automatic send_item(input logic [IW-1:0] d, input logic l);
        int t;
        logic ok;
        t = 0;
        S_AXIS_tdata = d;
        S_AXIS_tlast = l;
        S_AXIS_tvalid = 1'b1;
        do begin
            @(negedge clk);
            ok = S_AXIS_tready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 3000);
        if (!ok) chk("s_timeout", 0, 1);
    endtask

    task automatic idle();
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (got.size() < n && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (got.size() < n) chk("beat_timeout", got.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [IW-1:0] rand_item();
        logic [IW-1:0] v;
        for (int i = 0; i < IW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [IW-1:0] ramp_item(input logic [63:0] base);
        logic [IW-1:0] v;
        for (int k = 0; k < R; k++) v[k*OW +: OW] = base + 64'(k);
        return v;
    endfunction

    initial begin
        int base;
        int hb;
        int nl;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // Reset in the middle of an item, at beat index 5.
        base = got.size();
        send_item(ramp_item(64'h2000), 1'b1);
        idle();
        wait_beats(base + 4);
        chk("pre_rst_idx5", got.size(), base + 5);
        rst_n = 1'b0;
        #1;
        chk("async_m_valid", M_AXIS_tvalid, 0);
        chk("async_m_data", M_AXIS_tdata, 0);
        chk("async_m_last", M_AXIS_tlast, 0);
        chk("async_s_ready", S_AXIS_tready, 1);
        chk("async_items", items_done, 0);
        cycles(3);
        rst_n = 1'b1;
        cycles(6);
        chk("no_stray_beats", got.size(), base + 5);
        chk("post_rst_ready", S_AXIS_tready, 1);
        chk("post_rst_items", items_done, 0);

        // Single ramp item, downstream always ready.
        base = got.size();
        send_item(ramp_item(64'h1000), 1'b1);
        idle();
        wait_beats(base + 16);
        chk("single_b0", got[base].d, 64'h1000);
        chk("single_b15", got[base + 15].d, 64'h100F);
        chk("single_b15_last", got[base + 15].l, 1);
        nl = 0;
        for (int i = 0; i < 16; i++) nl += int'(got[base + i].l);
        chk("single_nlast", nl, 1);
        chk("single_span", got[base + 15].c - got[base].c, 15);
        chk("single_items", items_done, 1);

        // Three items back to back, tlast pattern 0,0,1.
        base = got.size();
        hb = hs.size();
        send_item(ramp_item(64'hA000), 1'b0);
        send_item(ramp_item(64'hB000), 1'b0);
        send_item(ramp_item(64'hC000), 1'b1);
        idle();
        wait_beats(base + 48);
        chk("b2b_hs0", hs[hb], base);
        chk("b2b_hs1", hs[hb + 1], base + 16);
        chk("b2b_hs2", hs[hb + 2], base + 32);
        chk("b2b_span", got[base + 47].c - got[base].c, 47);
        chk("b2b_b16", got[base + 16].d, 64'hB000);
        nl = 0;
        for (int i = 0; i < 48; i++) nl += int'(got[base + i].l);
        chk("b2b_nlast", nl, 1);
        chk("b2b_last47", got[base + 47].l, 1);
        chk("b2b_items", items_done, 4);

        // Random backpressure over four random items.
        base = got.size();
        rnd = 1'b1;
        for (int i = 0; i < 4; i++) send_item(rand_item(), 1'($urandom_range(0, 1)));
        idle();
        wait_beats(base + 64);
        rnd = 1'b0;
        cycles(2);
        chk("bp_items", items_done, 8);

        // Upstream holds a new item while the current one is at index 3.
        base = got.size();
        hb = hs.size();
        send_item(ramp_item(64'h3000), 1'b0);
        idle();
        wait_beats(base + 2);
        chk("hold_idx3", got.size(), base + 3);
        chk("hold_ready_low", S_AXIS_tready, 0);
        send_item(ramp_item(64'h4000), 1'b1);
        idle();
        chk("hold_taken_at15", hs[hb + 1], base + 16);
        wait_beats(base + 32);
        chk("hold_b16", got[base + 16].d, 64'h4000);
        chk("hold_b31", got[base + 31].d, 64'h400F);
        chk("hold_items", items_done, 10);

        // Counter wrap via a direct deposit.
        dut.done_cnt = 32'hFFFF_FFFF;
        model_done = 32'hFFFF_FFFF;
        cycles(1);
        base = got.size();
        send_item(rand_item(), 1'b0);
        idle();
        wait_beats(base + 16);
        chk("wrap_items", items_done, 0);
        chk("final_queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
